// File: rtl/wb_lsu_master.sv
// wb_lsu_master: load/store unit front end that turns single CPU requests
// into classic Wishbone master cycles. It handles byte/half/word lane
// steering, load sign/zero extension, misalignment rejection, slave retry
// with a one-cycle backoff, and a single-cycle completion strobe.
module wb_lsu_master #(
  parameter int MAX_RETRY = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  // CPU request side
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_wdata_i,
  // CPU response side
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  // Wishbone master
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  output logic [31:0] adr_o,
  output logic [3:0]  sel_o,
  output logic [31:0] dat_o,
  input  logic [31:0] dat_i,
  input  logic        ack_i,
  input  logic        err_i,
  input  logic        rty_i
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BUS     = 2'd1;
  localparam logic [1:0] ST_BACKOFF = 2'd2;
  localparam logic [1:0] ST_RESP    = 2'd3;

  localparam logic [3:0] MAX_RETRY_C = 4'(MAX_RETRY);

  // Size encodings on req_size_i
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // ---------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------

  // Size 3 is never legal; half needs even address, word needs 4-byte alignment.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lo[0];
      SZ_WORD: bad = (lo != 2'd0);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Byte-enable pattern for the addressed lanes.
  function automatic logic [3:0] sel_calc(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] sel;
    case (size)
      SZ_BYTE: sel = 4'b0001 << lo;
      SZ_HALF: sel = 4'b0011 << lo;
      default: sel = 4'b1111;
    endcase
    return sel;
  endfunction

  // Store data replicated across all lanes so the slave picks it up via sel.
  function automatic logic [31:0] dat_calc(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] dat;
    case (size)
      SZ_BYTE: dat = {4{wdata[7:0]}};
      SZ_HALF: dat = {2{wdata[15:0]}};
      default: dat = wdata;
    endcase
    return dat;
  endfunction

  // Pick the addressed lane out of the bus word and extend it to 32 bits.
  function automatic logic [31:0] load_extend(input logic [1:0]  size,
                                              input logic        uns,
                                              input logic [1:0]  lo,
                                              input logic [31:0] data);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (lo)
      2'd0:    b = data[7:0];
      2'd1:    b = data[15:8];
      2'd2:    b = data[23:16];
      default: b = data[31:24];
    endcase
    h = lo[1] ? data[31:16] : data[15:0];
    case (size)
      SZ_BYTE: res = uns ? {24'd0, b} : {{24{b[7]}}, b};
      SZ_HALF: res = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: res = data;
    endcase
    return res;
  endfunction

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [1:0]  state_r;
  logic [3:0]  retry_r;
  logic        we_r;
  logic [31:0] addr_r;
  logic [1:0]  size_r;
  logic        uns_r;
  logic [31:0] wdata_r;

  logic        cyc_r;
  logic        stb_r;
  logic        we_out_r;
  logic [31:0] adr_r;
  logic [3:0]  sel_r;
  logic [31:0] dat_out_r;

  logic        rsp_valid_r;
  logic [31:0] rsp_rdata_r;
  logic        rsp_err_r;

  logic        accept_s;
  logic [1:0]  next_state_s;
  logic [3:0]  retry_next_s;
  logic        rsp_set_s;
  logic        rsp_err_s;
  logic [31:0] rsp_data_s;

  logic        cur_we_s;
  logic [31:0] cur_addr_s;
  logic [1:0]  cur_size_s;
  logic [31:0] cur_wdata_s;

  // Ready only when idle and out of reset, so nothing is accepted during reset.
  assign req_ready_o = rst_i && (state_r == ST_IDLE);
  assign accept_s    = req_valid_i && req_ready_o;

  assign cyc_o       = cyc_r;
  assign stb_o       = stb_r;
  assign we_o        = we_out_r;
  assign adr_o       = adr_r;
  assign sel_o       = sel_r;
  assign dat_o       = dat_out_r;
  assign rsp_valid_o = rsp_valid_r;
  assign rsp_rdata_o = rsp_rdata_r;
  assign rsp_err_o   = rsp_err_r;

  // Request fields feeding the bus registers: live inputs on the accept edge,
  // latched copies afterwards so every retry re-issues the same cycle.
  always_comb begin
    if (state_r == ST_IDLE) begin
      cur_we_s    = req_we_i;
      cur_addr_s  = req_addr_i;
      cur_size_s  = req_size_i;
      cur_wdata_s = req_wdata_i;
    end else begin
      cur_we_s    = we_r;
      cur_addr_s  = addr_r;
      cur_size_s  = size_r;
      cur_wdata_s = wdata_r;
    end
  end

  // Next-state, retry bookkeeping and response value selection.
  always_comb begin
    next_state_s = state_r;
    retry_next_s = retry_r;
    rsp_set_s    = 1'b0;
    rsp_err_s    = 1'b0;
    rsp_data_s   = 32'd0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (misaligned(req_size_i, req_addr_i[1:0])) begin
            next_state_s = ST_RESP;
            rsp_set_s    = 1'b1;
            rsp_err_s    = 1'b1;
          end else begin
            next_state_s = ST_BUS;
            retry_next_s = 4'd0;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_BUS: begin
        if (err_i) begin
          next_state_s = ST_RESP;
          rsp_set_s    = 1'b1;
          rsp_err_s    = 1'b1;
        end else if (ack_i) begin
          next_state_s = ST_RESP;
          rsp_set_s    = 1'b1;
          if (we_r) begin
            rsp_data_s = 32'd0;
          end else begin
            rsp_data_s = load_extend(size_r, uns_r, addr_r[1:0], dat_i);
          end
        end else if (rty_i) begin
          if (retry_r == MAX_RETRY_C) begin
            next_state_s = ST_RESP;
            rsp_set_s    = 1'b1;
            rsp_err_s    = 1'b1;
          end else begin
            next_state_s = ST_BACKOFF;
            retry_next_s = retry_r + 4'd1;
          end
        end else begin
          // No termination yet: wait on the slave without a timeout.
          next_state_s = ST_BUS;
        end
      end
      ST_BACKOFF: begin
        next_state_s = ST_BUS;
      end
      ST_RESP: begin
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // FSM state, retry counter and latched request fields.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_r <= ST_IDLE;
      retry_r <= 4'd0;
      we_r    <= 1'b0;
      addr_r  <= 32'd0;
      size_r  <= 2'd0;
      uns_r   <= 1'b0;
      wdata_r <= 32'd0;
    end else begin
      state_r <= next_state_s;
      retry_r <= retry_next_s;
      if (accept_s) begin
        we_r    <= req_we_i;
        addr_r  <= req_addr_i;
        size_r  <= req_size_i;
        uns_r   <= req_unsigned_i;
        wdata_r <= req_wdata_i;
      end
    end
  end

  // Registered Wishbone outputs: driven only while the next state is BUS,
  // all zero otherwise so idle/backoff cycles present a quiet bus.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cyc_r     <= 1'b0;
      stb_r     <= 1'b0;
      we_out_r  <= 1'b0;
      adr_r     <= 32'd0;
      sel_r     <= 4'd0;
      dat_out_r <= 32'd0;
    end else if (next_state_s == ST_BUS) begin
      cyc_r     <= 1'b1;
      stb_r     <= 1'b1;
      we_out_r  <= cur_we_s;
      adr_r     <= {cur_addr_s[31:2], 2'b00};
      sel_r     <= sel_calc(cur_size_s, cur_addr_s[1:0]);
      dat_out_r <= cur_we_s ? dat_calc(cur_size_s, cur_wdata_s) : 32'd0;
    end else begin
      cyc_r     <= 1'b0;
      stb_r     <= 1'b0;
      we_out_r  <= 1'b0;
      adr_r     <= 32'd0;
      sel_r     <= 4'd0;
      dat_out_r <= 32'd0;
    end
  end

  // Completion strobe for one cycle in RESP; data and error hold between responses.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'd0;
      rsp_err_r   <= 1'b0;
    end else if (rsp_set_s) begin
      rsp_valid_r <= 1'b1;
      rsp_rdata_r <= rsp_data_s;
      rsp_err_r   <= rsp_err_s;
    end else begin
      rsp_valid_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_lsu_master.sv
// Self-checking bench for wb_lsu_master: a registered Wishbone slave model,
// a response scoreboard queue, and one task per feature.
module tb_wb_lsu_master;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        cyc, stb, we;
  logic [31:0] adr, dat_o;
  logic [3:0]  sel;
  logic [31:0] slave_rdata = 32'd0;
  logic        ack = 1'b0, err = 1'b0, rty = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct packed { logic err; logic [31:0] rdata; } rsp_t;
  rsp_t exp_q[$];

  // Slave configuration: number of rty answers, then final kind (0 ack, 1 err, 2 never answer)
  int       rty_cfg = 0;
  int       rty_given = 0;
  int       final_kind = 0;

  always #5 clk = ~clk;

  wb_lsu_master #(.MAX_RETRY(3)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_size_i(req_size), .req_unsigned_i(req_unsigned),
    .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .cyc_o(cyc), .stb_o(stb), .we_o(we), .adr_o(adr), .sel_o(sel), .dat_o(dat_o),
    .dat_i(slave_rdata), .ack_i(ack), .err_i(err), .rty_i(rty)
  );

  // Registered slave: answers one cycle after it first sees cyc&stb.
  always @(posedge clk) begin
    if (!rst) begin
      ack <= 1'b0; err <= 1'b0; rty <= 1'b0; rty_given <= 0;
    end else begin
      ack <= 1'b0; err <= 1'b0; rty <= 1'b0;
      if (rsp_valid) rty_given <= 0;
      if (cyc && stb && !(ack || err || rty)) begin
        if (rty_given < rty_cfg) begin
          rty <= 1'b1; rty_given <= rty_given + 1;
        end else if (final_kind == 0) ack <= 1'b1;
        else if (final_kind == 1) err <= 1'b1;
      end
    end
  end

  // Observations gathered by collect()
  bit          o_got, o_same, o_clean, o_vafter, o_rafter;
  logic        o_err, o_we;
  logic [31:0] o_rdata, o_adr, o_dat, o_rdafter;
  logic [3:0]  o_sel;
  int          o_lat, o_att, o_gap;

  // Drive one request for the accept edge; returns on the following negedge.
  task automatic drive_req(input logic w, input logic [31:0] a, input logic [1:0] s,
                           input logic u, input logic [31:0] d);
    req_we = w; req_addr = a; req_size = s; req_unsigned = u; req_wdata = d;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Watch the bus and response until rsp_valid (bounded), recording what was seen.
  task automatic collect(input int budget);
    logic prev_cyc = 1'b0;
    int gap = 0;
    o_got = 0; o_lat = 0; o_att = 0; o_same = 1; o_clean = 1; o_gap = 0;
    o_adr = 32'd0; o_sel = 4'd0; o_dat = 32'd0; o_we = 1'b0;
    o_err = 1'b0; o_rdata = 32'd0; o_vafter = 1'b0; o_rafter = 1'b0; o_rdafter = 32'd0;
    for (int i = 0; i < budget; i++) begin
      o_lat = i + 1;
      if (cyc === 1'b1) begin
        if (!prev_cyc) begin
          if (o_att == 0) begin
            o_adr = adr; o_sel = sel; o_dat = dat_o; o_we = we;
          end else if (gap > o_gap) o_gap = gap;
          o_att++; gap = 0;
        end
        if (adr !== o_adr || sel !== o_sel || dat_o !== o_dat || we !== o_we || stb !== 1'b1)
          o_same = 0;
      end else begin
        if (adr !== 32'd0 || sel !== 4'd0 || dat_o !== 32'd0 || we !== 1'b0 || stb !== 1'b0)
          o_clean = 0;
        if (o_att > 0) gap++;
      end
      prev_cyc = cyc;
      if (rsp_valid === 1'b1) begin
        o_got = 1; o_err = rsp_err; o_rdata = rsp_rdata;
        @(negedge clk);
        o_vafter = rsp_valid; o_rafter = req_ready; o_rdafter = rsp_rdata;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if ({cyc, stb, we, adr, sel, dat_o} !== 70'd0) begin errors++;
      $display("FAIL reset_bus: got cyc=%b stb=%b we=%b adr=%h sel=%b dat=%h want all 0", cyc, stb, we, adr, sel, dat_o); end
    checks++; if ({rsp_valid, rsp_rdata, rsp_err} !== 34'd0) begin errors++;
      $display("FAIL reset_rsp: got v=%b d=%h e=%b want 0", rsp_valid, rsp_rdata, rsp_err); end
    checks++; if (req_ready !== 1'b0) begin errors++;
      $display("FAIL reset_ready_low: got %b want 0", req_ready); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++;
      $display("FAIL reset_ready_high: got %b want 1", req_ready); end
  endtask

  task automatic test_word_store();
    rsp_t e;
    final_kind = 0; rty_cfg = 0;
    exp_q.push_back(rsp_t'{1'b0, 32'h0});
    drive_req(1'b1, 32'h1000_0004, 2'd2, 1'b0, 32'hDEADBEEF);
    collect(50);
    checks++; if (o_att !== 1) begin errors++; $display("FAIL ws_attempts: got %0d want 1", o_att); end
    checks++; if ({o_adr, o_sel, o_dat, o_we} !== {32'h1000_0004, 4'b1111, 32'hDEADBEEF, 1'b1}) begin errors++;
      $display("FAIL ws_bus: got adr=%h sel=%b dat=%h we=%b want 10000004 1111 deadbeef 1", o_adr, o_sel, o_dat, o_we); end
    checks++; if (o_lat !== 3) begin errors++; $display("FAIL ws_latency: got %0d want 3", o_lat); end
    checks++; if (!o_same || !o_clean) begin errors++; $display("FAIL ws_stable: got same=%b clean=%b want 1 1", o_same, o_clean); end
    checks++; if (!o_got || exp_q.size() == 0) begin errors++; $display("FAIL ws_rsp: got %b want 1", o_got); end
    else begin
      e = exp_q.pop_front();
      checks++; if ({o_err, o_rdata} !== e) begin errors++;
        $display("FAIL ws_rsp_data: got e=%b d=%h want e=%b d=%h", o_err, o_rdata, e.err, e.rdata); end
      checks++; if (o_vafter !== 1'b0 || o_rafter !== 1'b1) begin errors++;
        $display("FAIL ws_one_cycle: got valid_after=%b ready_after=%b want 0 1", o_vafter, o_rafter); end
    end
  endtask

  task automatic test_loads();
    logic [31:0] t_addr[6] = '{32'h3, 32'h3, 32'h2, 32'h1, 32'h0, 32'h8};
    logic [1:0]  t_size[6] = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd1, 2'd2};
    logic        t_uns[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] t_dat[6]  = '{32'h80AABBCC, 32'h80AABBCC, 32'h80AABBCC, 32'h80AABBCC, 32'h80AA7FCC, 32'h80AABBCC};
    logic [3:0]  t_sel[6]  = '{4'b1000, 4'b1000, 4'b1100, 4'b0010, 4'b0011, 4'b1111};
    logic [31:0] t_adr[6]  = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h8};
    logic [31:0] t_exp[6]  = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80AA, 32'h000000BB, 32'h00007FCC, 32'h80AABBCC};
    rsp_t e;
    final_kind = 0; rty_cfg = 0;
    for (int i = 0; i < 6; i++) begin
      slave_rdata = t_dat[i];
      exp_q.push_back(rsp_t'{1'b0, t_exp[i]});
      drive_req(1'b0, t_addr[i], t_size[i], t_uns[i], 32'hFFFF_FFFF);
      collect(50);
      checks++; if ({o_adr, o_sel, o_dat, o_we} !== {t_adr[i], t_sel[i], 32'h0, 1'b0}) begin errors++;
        $display("FAIL ld%0d_bus: got adr=%h sel=%b dat=%h we=%b want %h %b 0 0", i, o_adr, o_sel, o_dat, o_we, t_adr[i], t_sel[i]); end
      checks++; if (!o_got || exp_q.size() == 0) begin errors++; $display("FAIL ld%0d_rsp: got %b want 1", i, o_got); end
      else begin
        e = exp_q.pop_front();
        checks++; if ({o_err, o_rdata} !== e) begin errors++;
          $display("FAIL ld%0d_data: got e=%b d=%h want e=%b d=%h", i, o_err, o_rdata, e.err, e.rdata); end
        checks++; if (o_rdafter !== e.rdata) begin errors++;
          $display("FAIL ld%0d_hold: got %h want %h", i, o_rdafter, e.rdata); end
      end
    end
  endtask

  task automatic test_stores();
    logic [31:0] t_addr[4] = '{32'h2, 32'h1, 32'h104, 32'h0};
    logic [1:0]  t_size[4] = '{2'd1, 2'd0, 2'd2, 2'd1};
    logic [31:0] t_wd[4]   = '{32'h00001234, 32'hFFFFFF5A, 32'hCAFEF00D, 32'hABCD9876};
    logic [3:0]  t_sel[4]  = '{4'b1100, 4'b0010, 4'b1111, 4'b0011};
    logic [31:0] t_dat[4]  = '{32'h12341234, 32'h5A5A5A5A, 32'hCAFEF00D, 32'h98769876};
    logic [31:0] t_adr[4]  = '{32'h0, 32'h0, 32'h104, 32'h0};
    rsp_t e;
    final_kind = 0; rty_cfg = 0; slave_rdata = 32'h1111_2222;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(rsp_t'{1'b0, 32'h0});
      drive_req(1'b1, t_addr[i], t_size[i], 1'b0, t_wd[i]);
      collect(50);
      checks++; if ({o_adr, o_sel, o_dat, o_we} !== {t_adr[i], t_sel[i], t_dat[i], 1'b1}) begin errors++;
        $display("FAIL st%0d_bus: got adr=%h sel=%b dat=%h we=%b want %h %b %h 1", i, o_adr, o_sel, o_dat, o_we, t_adr[i], t_sel[i], t_dat[i]); end
      checks++; if (!o_got || exp_q.size() == 0) begin errors++; $display("FAIL st%0d_rsp: got %b want 1", i, o_got); end
      else begin
        e = exp_q.pop_front();
        checks++; if ({o_err, o_rdata} !== e) begin errors++;
          $display("FAIL st%0d_data: got e=%b d=%h want e=%b d=%h", i, o_err, o_rdata, e.err, e.rdata); end
      end
    end
  endtask

  task automatic test_misaligned();
    logic        t_we[4]   = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] t_addr[4] = '{32'h1002, 32'h1, 32'h0, 32'h3};
    logic [1:0]  t_size[4] = '{2'd2, 2'd1, 2'd3, 2'd2};
    rsp_t e;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(rsp_t'{1'b1, 32'h0});
      drive_req(t_we[i], t_addr[i], t_size[i], 1'b0, 32'h5555_AAAA);
      collect(20);
      checks++; if (o_att !== 0 || o_lat !== 1) begin errors++;
        $display("FAIL mis%0d_nobus: got attempts=%0d latency=%0d want 0 1", i, o_att, o_lat); end
      checks++; if (!o_got || exp_q.size() == 0) begin errors++; $display("FAIL mis%0d_rsp: got %b want 1", i, o_got); end
      else begin
        e = exp_q.pop_front();
        checks++; if ({o_err, o_rdata} !== e) begin errors++;
          $display("FAIL mis%0d_data: got e=%b d=%h want e=%b d=%h", i, o_err, o_rdata, e.err, e.rdata); end
        checks++; if (o_rafter !== 1'b1) begin errors++; $display("FAIL mis%0d_ready: got %b want 1", i, o_rafter); end
      end
    end
  endtask

  task automatic test_retry();
    int          t_rty[3]  = '{2, 3, 4};
    logic        t_we[3]   = '{1'b0, 1'b1, 1'b0};
    logic [31:0] t_addr[3] = '{32'h20, 32'h21, 32'h24};
    logic [1:0]  t_size[3] = '{2'd2, 2'd0, 2'd2};
    int          t_att[3]  = '{3, 4, 4};
    logic        t_err[3]  = '{1'b0, 1'b0, 1'b1};
    logic [31:0] t_rd[3]   = '{32'h12345678, 32'h0, 32'h0};
    rsp_t e;
    final_kind = 0; slave_rdata = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      rty_cfg = t_rty[i];
      exp_q.push_back(rsp_t'{t_err[i], t_rd[i]});
      drive_req(t_we[i], t_addr[i], t_size[i], 1'b0, 32'h0000_0077);
      collect(60);
      checks++; if (o_att !== t_att[i]) begin errors++; $display("FAIL rty%0d_attempts: got %0d want %0d", i, o_att, t_att[i]); end
      checks++; if (o_gap !== 1) begin errors++; $display("FAIL rty%0d_gap: got %0d want 1", i, o_gap); end
      checks++; if (!o_same || !o_clean) begin errors++; $display("FAIL rty%0d_reissue: got same=%b clean=%b want 1 1", i, o_same, o_clean); end
      checks++; if (!o_got || exp_q.size() == 0) begin errors++; $display("FAIL rty%0d_rsp: got %b want 1", i, o_got); end
      else begin
        e = exp_q.pop_front();
        checks++; if ({o_err, o_rdata} !== e) begin errors++;
          $display("FAIL rty%0d_data: got e=%b d=%h want e=%b d=%h", i, o_err, o_rdata, e.err, e.rdata); end
      end
    end
    checks++; if (o_dat !== 32'h0 || o_sel !== 4'b1111) begin errors++;
      $display("FAIL rty_last_bus: got dat=%h sel=%b want 0 1111", o_dat, o_sel); end
    rty_cfg = 0;
  endtask

  task automatic test_bus_err();
    rsp_t e;
    final_kind = 1; rty_cfg = 0; slave_rdata = 32'hFFFF_FFFF;
    exp_q.push_back(rsp_t'{1'b1, 32'h0});
    drive_req(1'b0, 32'h30, 2'd2, 1'b0, 32'h0);
    collect(50);
    checks++; if (o_att !== 1) begin errors++; $display("FAIL err_attempts: got %0d want 1", o_att); end
    checks++; if (!o_got || exp_q.size() == 0) begin errors++; $display("FAIL err_rsp: got %b want 1", o_got); end
    else begin
      e = exp_q.pop_front();
      checks++; if ({o_err, o_rdata} !== e) begin errors++;
        $display("FAIL err_data: got e=%b d=%h want e=%b d=%h", o_err, o_rdata, e.err, e.rdata); end
    end
    final_kind = 0;
  endtask

  task automatic test_back_to_back();
    rsp_t e;
    final_kind = 0; rty_cfg = 0;
    for (int i = 0; i < 2; i++) begin
      slave_rdata = (i == 0) ? 32'hAAAA_5555 : 32'h0F0F_F0F0;
      exp_q.push_back(rsp_t'{1'b0, slave_rdata});
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b%0d_ready: got %b want 1", i, req_ready); end
      drive_req(1'b0, 32'h200 + 32'(i * 4), 2'd2, 1'b0, 32'h0);
      collect(50);
      checks++; if (!o_got || exp_q.size() == 0) begin errors++; $display("FAIL b2b%0d_rsp: got %b want 1", i, o_got); end
      else begin
        e = exp_q.pop_front();
        checks++; if ({o_err, o_rdata} !== e || o_lat !== 3) begin errors++;
          $display("FAIL b2b%0d_data: got e=%b d=%h lat=%0d want e=%b d=%h lat=3", i, o_err, o_rdata, o_lat, e.err, e.rdata); end
      end
    end
  endtask

  task automatic test_reset_mid_bus();
    bit saw_rsp = 0;
    final_kind = 2; rty_cfg = 0;
    drive_req(1'b1, 32'h40, 2'd2, 1'b0, 32'h1357_9BDF);
    @(negedge clk);
    checks++; if (cyc !== 1'b1) begin errors++; $display("FAIL rstbus_cyc_before: got %b want 1", cyc); end
    rst = 1'b0;
    @(negedge clk);
    saw_rsp = rsp_valid;
    checks++; if (cyc !== 1'b0 || stb !== 1'b0) begin errors++;
      $display("FAIL rstbus_cyc_after: got cyc=%b stb=%b want 0 0", cyc, stb); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rstbus_ready_low: got %b want 0", req_ready); end
    @(negedge clk);
    saw_rsp = saw_rsp | rsp_valid;
    rst = 1'b1;
    repeat (2) begin @(negedge clk); saw_rsp = saw_rsp | rsp_valid; end
    checks++; if (saw_rsp) begin errors++; $display("FAIL rstbus_no_rsp: got rsp_valid=1 want 0"); end
    checks++; if (req_ready !== 1'b1 || cyc !== 1'b0) begin errors++;
      $display("FAIL rstbus_ready_high: got ready=%b cyc=%b want 1 0", req_ready, cyc); end
    final_kind = 0;
  endtask

  initial begin
    test_reset();
    test_word_store();
    test_loads();
    test_stores();
    test_misaligned();
    test_retry();
    test_bus_err();
    test_back_to_back();
    test_reset_mid_bus();
    test_word_store();
    checks++; if (exp_q.size() != 0) begin errors++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_lsu_master.md
WB_LSU_MASTER -- requirements
Module: wb_lsu_master

Interface
REQ-001 SHALL have parameter MAX_RETRY, default 3: rty_i retries permitted per request; legal range 1..15.
REQ-002 SHALL have port clk_i  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port req_valid_i  input  1  CPU request valid.
REQ-005 SHALL have port req_ready_o  output  1  request accepted when req_valid_i is also high.
REQ-006 SHALL have port req_we_i  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_addr_i  input  32  byte address.
REQ-008 SHALL have port req_size_i  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
REQ-009 SHALL have port req_unsigned_i  input  1  load zero-extends when 1, sign-extends when 0.
REQ-010 SHALL have port req_wdata_i  input  32  store data, right-justified.
REQ-011 SHALL have port rsp_valid_o  output  1  one-cycle completion strobe.
REQ-012 SHALL have port rsp_rdata_o  output  32  extended load data.
REQ-013 SHALL have port rsp_err_o  output  1  failure flag, qualified by rsp_valid_o.
REQ-014 SHALL have Wishbone master outputs cyc_o, stb_o, we_o (1 each), adr_o (32), sel_o (4) and dat_o (32).
REQ-015 SHALL have Wishbone master inputs dat_i (32), ack_i, err_i and rty_i (1 each).

Function
REQ-016 SHALL implement four states: IDLE, BUS, BACKOFF and RESP.
REQ-017 SHALL drive req_ready_o high only in IDLE; a request is accepted on an edge where req_valid_i and req_ready_o are both high, and all request fields are latched on that edge.
REQ-018 SHALL treat a request as misaligned when req_size_i is 1 and addr[0] is 1, when req_size_i is 2 and addr[1:0] is nonzero, or when req_size_i is 3; a misaligned request goes IDLE->RESP with rsp_err_o 1, rsp_rdata_o 0, and no bus cycle.
REQ-019 SHALL move an aligned request IDLE->BUS with the retry counter cleared.
REQ-020 SHALL, in BUS, drive cyc_o and stb_o high, adr_o = {addr[31:2], 2'b00}, and we_o = the latched req_we_i; all Wishbone outputs are registered and held stable until the cycle is terminated.
REQ-021 SHALL set sel_o to 4'b0001<<addr[1:0] for a byte, 4'b0011<<addr[1:0] for a half and 4'b1111 for a word.
REQ-022 SHALL set dat_o to {4{wdata[7:0]}} for a byte, {2{wdata[15:0]}} for a half and wdata for a word.
REQ-023 SHALL drive dat_o = 0 on loads, and drive adr_o, sel_o, dat_o and we_o = 0 whenever cyc_o is low.
REQ-024 SHALL, in BUS, apply termination priority err_i > ack_i > rty_i; with none of them high, remain in BUS indefinitely (no timeout).
REQ-025 SHALL on ack_i: capture the dat_i lane selected by addr[1:0], zero- or sign-extend it per size and req_unsigned_i, then go to RESP with rsp_err_o 0; a store returns rsp_rdata_o 0.
REQ-026 SHALL on err_i: go to RESP with rsp_err_o 1 and rsp_rdata_o 0.
REQ-027 SHALL on rty_i: if the retry counter equals MAX_RETRY, go to RESP with rsp_err_o 1; otherwise increment the counter and enter BACKOFF.
REQ-028 SHALL make BACKOFF last exactly one cycle with cyc_o and stb_o low, then return to BUS re-issuing identical adr_o, sel_o, dat_o and we_o; total bus attempts are at most MAX_RETRY+1.
REQ-029 SHALL size the retry counter at 4 bits so that it never wraps.
REQ-030 SHALL, in RESP, drive rsp_valid_o high for exactly one cycle, then return to IDLE; the response has no backpressure.
REQ-031 SHALL drop cyc_o and stb_o on the edge that samples the termination, so they are low throughout RESP.
REQ-032 SHALL hold rsp_rdata_o and rsp_err_o at their last values outside RESP.
REQ-033 SHALL give latency, with a slave that registers ack one cycle after seeing stb: acceptance edge E0; cyc_o high after E0; ack sampled at E2; rsp_valid_o high between E2 and E3.
REQ-034 SHALL allow a new request to be accepted on the first IDLE cycle after RESP, giving back-to-back throughput of one request per 3 cycles minimum.

Reset
REQ-035 SHALL, on any edge with rst_i low, enter IDLE, clear the retry counter, and set cyc_o, stb_o, we_o, adr_o, sel_o, dat_o, rsp_valid_o, rsp_rdata_o and rsp_err_o to 0.
REQ-036 SHALL, when reset occurs mid-BUS or mid-BACKOFF, abandon the transaction with no rsp_valid_o pulse; cyc_o is low on the cycle after the reset edge.
REQ-037 SHALL hold req_ready_o low while rst_i is low.

Verification
REQ-038 SHALL cover a word store at 0x1000_0004 with data 0xDEADBEEF: adr_o 0x1000_0004, sel_o 4'b1111, dat_o 0xDEADBEEF, we_o 1; ack -> single rsp_valid_o, rsp_err_o 0.
REQ-039 SHALL cover byte loads at 0x0000_0003 with dat_i 0x80AA_BBCC: sel_o 4'b1000; signed -> rsp_rdata_o 0xFFFF_FF80; unsigned -> 0x0000_0080.
REQ-040 SHALL cover a half store at 0x0000_0002 with data 0x0000_1234: sel_o 4'b1100, dat_o 0x1234_1234.
REQ-041 SHALL cover a word load at 0x0000_1002: cyc_o never high, rsp_valid_o with rsp_err_o 1 on the cycle after acceptance.
REQ-042 SHALL cover retries with MAX_RETRY 3: rty on two attempts then ack -> three bus attempts, each separated by one idle cycle, rsp_err_o 0; rty on four attempts -> rsp_err_o 1 and no fifth attempt.
REQ-043 SHALL cover reset asserted while in BUS: cyc_o 0 the next cycle, no rsp_valid_o, req_ready_o 1 after reset is released.
